// File: rtl/tdp18k_port_arb.sv
// -----------------------------------------------------------------------------
// tdp18k_port_arb
//
// Purpose:
//   Shares one port of a TDP18K block RAM among NUM_REQ requesters. A
//   round-robin arbiter grants at most one command per cycle. The granted
//   command is registered onto the RAM_* outputs one cycle later. A requester
//   may hold LOCK_i to keep the port for a burst of up to MAX_BURST
//   consecutive grants. Read data is routed back to the requester that issued
//   the read. A one-hot RVALID_o strobe marks which requester the data is for.
//
// Ports:
//   CLK_i        clock, all logic on the rising edge
//   RESET_ni     asynchronous active-low reset
//   REQ_i        per-requester command request
//   WE_i         per-requester direction (1 = write, 0 = read)
//   LOCK_i       per-requester request to keep the grant next cycle
//   ADDR_i       packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   BE_i         packed 2-bit byte enables
//   WDATA_i      packed write data
//   GNT_o        one-hot combinational grant (command accepted this cycle)
//   RVALID_o     one-hot read-data valid
//   RDATA_o      shared read data, qualified by RVALID_o
//   RAM_ADDR_o   registered RAM address
//   RAM_REN_o    registered RAM read enable
//   RAM_WEN_o    registered RAM write enable
//   RAM_BE_o     registered RAM byte enable
//   RAM_WDATA_o  registered RAM write data
//   RAM_RDATA_i  RAM read data
//   BUSY_o       a read is in flight or a locked burst is active
//
// Build option:
//   TDP18K_ARB_OREG_EN - define when the RAM output register is enabled.
//   RVALID_o then arrives 3 cycles after the grant instead of 2.
// -----------------------------------------------------------------------------
module tdp18k_port_arb #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 18,
    parameter int MAX_BURST = 8
) (
    input  logic                        CLK_i,
    input  logic                        RESET_ni,
    input  logic [NUM_REQ-1:0]          REQ_i,
    input  logic [NUM_REQ-1:0]          WE_i,
    input  logic [NUM_REQ-1:0]          LOCK_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   ADDR_i,
    input  logic [NUM_REQ*2-1:0]        BE_i,
    input  logic [NUM_REQ*DATA_W-1:0]   WDATA_i,
    output logic [NUM_REQ-1:0]          GNT_o,
    output logic [NUM_REQ-1:0]          RVALID_o,
    output logic [DATA_W-1:0]           RDATA_o,
    output logic [ADDR_W-1:0]           RAM_ADDR_o,
    output logic                        RAM_REN_o,
    output logic                        RAM_WEN_o,
    output logic [1:0]                  RAM_BE_o,
    output logic [DATA_W-1:0]           RAM_WDATA_o,
    input  logic [DATA_W-1:0]           RAM_RDATA_i,
    output logic                        BUSY_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef TDP18K_ARB_OREG_EN
    // Command register + RAM latency + RAM output register.
    localparam int PIPE_DEPTH = 3;
`else
    // Command register + RAM latency.
    localparam int PIPE_DEPTH = 2;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic               ram_ren_q, ram_ren_d;
    logic               ram_wen_q, ram_wen_d;
    logic [1:0]         ram_be_q, ram_be_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;

    // Read-return pipeline: one {valid, id} entry per cycle of read latency.
    logic               pipe_vld_q [PIPE_DEPTH];
    logic               pipe_vld_d [PIPE_DEPTH];
    logic [ID_W-1:0]    pipe_id_q  [PIPE_DEPTH];
    logic [ID_W-1:0]    pipe_id_d  [PIPE_DEPTH];

    // -------------------------------------------------------------------------
    // Unpack the per-requester command buses
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [1:0]         be_arr    [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = ADDR_i[gi*ADDR_W +: ADDR_W];
            assign be_arr[gi]    = BE_i[gi*2 +: 2];
            assign wdata_arr[gi] = WDATA_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    logic [NUM_REQ-1:0] gnt_vec;
    int                 srch_idx;

    always_comb begin
        gnt_any  = 1'b0;
        gnt_id   = '0;
        srch_idx = 0;
        if (state_q == ST_BURST) begin
            // The owner is the only candidate while a burst is active.
            if (REQ_i[owner_q]) begin
                gnt_any = 1'b1;
                gnt_id  = owner_q;
            end
        end else begin
            // Search ptr, ptr+1, ... with wrap. The first hit wins.
            for (int i = 0; i < NUM_REQ; i++) begin
                srch_idx = int'(ptr_q) + i;
                if (srch_idx >= NUM_REQ) begin
                    srch_idx = srch_idx - NUM_REQ;
                end
                if (!gnt_any && REQ_i[ID_W'(srch_idx)]) begin
                    gnt_any = 1'b1;
                    gnt_id  = ID_W'(srch_idx);
                end
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (gnt_any) begin
            gnt_vec[gnt_id] = 1'b1;
        end
    end

    assign GNT_o = gnt_vec;

    // -------------------------------------------------------------------------
    // Burst FSM and round-robin pointer
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]   cnt_inc;
    logic [ID_W-1:0]    ptr_adv;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cnt_inc = cnt_q + 1'b1;
        ptr_adv = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    if (LOCK_i[gnt_id] && (MAX_BURST > 1)) begin
                        // The first grant of a burst counts as grant #1. The
                        // pointer stays put until the burst ends.
                        state_d = ST_BURST;
                        owner_d = gnt_id;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        // Plain grant. With MAX_BURST == 1 a locked grant is
                        // also the last one, so it rotates the same way.
                        ptr_d = ptr_adv;
                    end
                end
            end

            ST_BURST: begin
                if (!REQ_i[owner_q]) begin
                    // Owner abandoned the burst. Nothing is granted now, and
                    // normal arbitration resumes next cycle.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!LOCK_i[owner_q] || (cnt_inc == CNT_W'(MAX_BURST))) begin
                    // This grant is the last of the burst. Force rotation
                    // past the owner.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = ptr_adv;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // RAM command register
    // -------------------------------------------------------------------------
    always_comb begin
        // Address, byte-enable and data hold when nothing is granted. Only the
        // strobes drop.
        ram_addr_d  = ram_addr_q;
        ram_be_d    = ram_be_q;
        ram_wdata_d = ram_wdata_q;
        ram_ren_d   = 1'b0;
        ram_wen_d   = 1'b0;
        if (gnt_any) begin
            ram_addr_d  = addr_arr[gnt_id];
            ram_be_d    = be_arr[gnt_id];
            ram_wdata_d = wdata_arr[gnt_id];
            ram_ren_d   = ~WE_i[gnt_id];
            ram_wen_d   = WE_i[gnt_id];
        end
    end

    assign RAM_ADDR_o  = ram_addr_q;
    assign RAM_REN_o   = ram_ren_q;
    assign RAM_WEN_o   = ram_wen_q;
    assign RAM_BE_o    = ram_be_q;
    assign RAM_WDATA_o = ram_wdata_q;

    // -------------------------------------------------------------------------
    // Read-return pipeline
    // -------------------------------------------------------------------------
    always_comb begin
        pipe_vld_d[0] = gnt_any & ~WE_i[gnt_id];
        pipe_id_d[0]  = gnt_id;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    // The last pipeline stage lines up with the cycle in which RAM_RDATA_i
    // holds the data for that read.
    always_comb begin
        RVALID_o = '0;
        RDATA_o  = '0;
        if (pipe_vld_q[PIPE_DEPTH-1]) begin
            RVALID_o[pipe_id_q[PIPE_DEPTH-1]] = 1'b1;
            RDATA_o                           = RAM_RDATA_i;
        end
    end

    logic busy_any;

    always_comb begin
        busy_any = (state_q == ST_BURST);
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            busy_any = busy_any | pipe_vld_q[i];
        end
    end

    assign BUSY_o = busy_any;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Reset drops every in-flight read, so no stale RVALID_o appears after
    // release.
    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_id_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_vld_q[i] <= pipe_vld_d[i];
                pipe_id_q[i]  <= pipe_id_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tdp18k_port_arb.sv
// -----------------------------------------------------------------------------
// tb_tdp18k_port_arb
//
// Self-checking bench for tdp18k_port_arb.
//
// A transaction-level model holds the round-robin pointer, the burst owner and
// its grant count, the expected RAM command, and a queue of pending read
// returns stamped with their due cycle. Every cycle the model's expectations
// are compared against the DUT outputs. Directed scenarios also pin literal
// values.
// -----------------------------------------------------------------------------
module tb_tdp18k_port_arb;

    localparam int N    = 4;
    localparam int AW   = 14;
    localparam int DW   = 18;
    localparam int MAXB = 8;
`ifdef TDP18K_ARB_OREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req, we, lock;
    logic [N*AW-1:0]   addr_bus;
    logic [N*2-1:0]    be_bus;
    logic [N*DW-1:0]   wd_bus;
    logic [N-1:0]      gnt, rvalid;
    logic [DW-1:0]     rdata, ram_wdata, ram_rdata;
    logic [AW-1:0]     ram_addr;
    logic              ram_ren, ram_wen, busy;
    logic [1:0]        ram_be;

    tdp18k_port_arb #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MAXB)
    ) dut (
        .CLK_i       (clk),
        .RESET_ni    (rst_n),
        .REQ_i       (req),
        .WE_i        (we),
        .LOCK_i      (lock),
        .ADDR_i      (addr_bus),
        .BE_i        (be_bus),
        .WDATA_i     (wd_bus),
        .GNT_o       (gnt),
        .RVALID_o    (rvalid),
        .RDATA_o     (rdata),
        .RAM_ADDR_o  (ram_addr),
        .RAM_REN_o   (ram_ren),
        .RAM_WEN_o   (ram_wen),
        .RAM_BE_o    (ram_be),
        .RAM_WDATA_o (ram_wdata),
        .RAM_RDATA_i (ram_rdata),
        .BUSY_o      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model state ----------------
    typedef struct packed {
        int due;
        int id;
    } rd_t;

    rd_t            rq[$];
    int             cyc;
    int             m_ptr;
    int             m_owner;          // -1 when no burst is active
    int             m_cnt;            // grants given to the owner so far
    logic [AW-1:0]  e_addr;
    logic [1:0]     e_be;
    logic [DW-1:0]  e_wdata;
    logic           e_ren, e_wen;

    // Last sampled outputs, for literal checks made by the scenarios.
    logic [N-1:0]   seen_gnt, seen_rv;
    logic [DW-1:0]  seen_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        m_ptr   = 0;
        m_owner = -1;
        m_cnt   = 0;
        e_addr  = '0;
        e_be    = '0;
        e_wdata = '0;
        e_ren   = 1'b0;
        e_wen   = 1'b0;
    endtask

    // One clock cycle. Inputs are already applied. Outputs are compared at the
    // falling edge, the model advances, and the task returns 1 time unit after
    // the next rising edge.
    task automatic cycle();
        int            exp_g;
        int            k;
        logic [N-1:0]  exp_vec;
        logic [N-1:0]  exp_rv;
        logic [DW-1:0] exp_rd;
        logic          exp_busy;

        @(negedge clk);

        exp_g = -1;
        if (m_owner >= 0) begin
            if (req[m_owner]) exp_g = m_owner;
        end else begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (exp_g < 0 && req[k]) exp_g = k;
            end
        end
        exp_vec = '0;
        if (exp_g >= 0) exp_vec[exp_g] = 1'b1;

        exp_busy = (m_owner >= 0) || (rq.size() > 0);
        exp_rv   = '0;
        exp_rd   = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rv[rq[0].id] = 1'b1;
            exp_rd           = ram_rdata;
            void'(rq.pop_front());
        end

        chk("gnt",       32'(gnt),       32'(exp_vec));
        chk("rvalid",    32'(rvalid),    32'(exp_rv));
        chk("rdata",     32'(rdata),     32'(exp_rd));
        chk("busy",      32'(busy),      32'(exp_busy));
        chk("ram_ren",   32'(ram_ren),   32'(e_ren));
        chk("ram_wen",   32'(ram_wen),   32'(e_wen));
        chk("ram_addr",  32'(ram_addr),  32'(e_addr));
        chk("ram_be",    32'(ram_be),    32'(e_be));
        chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));

        seen_gnt   = gnt;
        seen_rv    = rvalid;
        seen_rdata = rdata;

        // Advance the model by one accepted (or refused) command.
        if (exp_g >= 0) begin
            e_addr  = addr_bus[exp_g*AW +: AW];
            e_be    = be_bus[exp_g*2 +: 2];
            e_wdata = wd_bus[exp_g*DW +: DW];
            e_ren   = ~we[exp_g];
            e_wen   = we[exp_g];
            if (!we[exp_g]) rq.push_back('{due: cyc + LAT, id: exp_g});
            if (m_owner < 0) begin
                if (lock[exp_g] && MAXB > 1) begin
                    m_owner = exp_g;
                    m_cnt   = 1;
                end else begin
                    m_ptr = (exp_g + 1) % N;
                end
            end else begin
                m_cnt++;
                if (!lock[exp_g] || m_cnt == MAXB) begin
                    m_owner = -1;
                    m_ptr   = (exp_g + 1) % N;
                end
            end
        end else begin
            e_ren = 1'b0;
            e_wen = 1'b0;
            if (m_owner >= 0) m_owner = -1;   // owner dropped its request
        end
        cyc++;

        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            addr_bus[i*AW +: AW] = AW'($urandom);
            be_bus[i*2 +: 2]     = 2'($urandom);
            wd_bus[i*DW +: DW]   = DW'($urandom);
        end
    endtask

    task automatic idle_inputs();
        req  = '0;
        we   = '0;
        lock = '0;
    endtask

    logic [N-1:0] rr_seq [8];
    int           drained;

    initial begin
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100; rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001; rr_seq[5] = 4'b0010; rr_seq[6] = 4'b0100; rr_seq[7] = 4'b1000;

        cyc       = 0;
        rst_n     = 1'b0;
        ram_rdata = '0;
        idle_inputs();
        addr_bus  = '0;
        be_bus    = '0;
        wd_bus    = '0;
        model_reset();

        // ---------------- reset state ----------------
        @(posedge clk); @(posedge clk); #1;
        chk("rst_gnt",    32'(gnt),      32'd0);
        chk("rst_rvalid", 32'(rvalid),   32'd0);
        chk("rst_ren",    32'(ram_ren),  32'd0);
        chk("rst_wen",    32'(ram_wen),  32'd0);
        chk("rst_addr",   32'(ram_addr), 32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        rst_n = 1'b1;
        cycle();

        // ---------------- all four read, round robin ----------------
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            rand_payload();
            cycle();
            chk("rr_gnt_seq", 32'(seen_gnt), 32'(rr_seq[i]));
            if (i >= LAT) chk("rr_rv_seq", 32'(seen_rv), 32'(rr_seq[i-LAT]));
        end
        idle_inputs();
        for (int i = 0; i < LAT + 1; i++) cycle();

        // ---------------- single read from requester 0 ----------------
        req = 4'b0001;
        rand_payload();
        cycle();
        idle_inputs();
        for (int j = 1; j <= LAT; j++) begin
            if (j == LAT) ram_rdata = 18'h3ABCD;
            cycle();
            if (j == LAT) begin
                chk("rd0_rvalid", 32'(seen_rv),    32'h1);
                chk("rd0_rdata",  32'(seen_rdata), 32'h3ABCD);
            end else begin
                chk("rd0_early", 32'(seen_rv), 32'h0);
            end
        end
        ram_rdata = '0;

        // ---------------- locked burst by requester 1, requester 3 waits ----
        req  = 4'b1010;
        lock = 4'b0010;
        we   = 4'b0000;
        for (int i = 0; i < MAXB; i++) begin
            rand_payload();
            cycle();
            chk("burst_gnt", 32'(seen_gnt), 32'b0010);
        end
        chk("burst_model_ptr", 32'(m_ptr), 32'd2);
        cycle();
        chk("burst_rotate_gnt", 32'(seen_gnt), 32'b1000);
        idle_inputs();
        for (int i = 0; i < LAT + 1; i++) cycle();

        // ---------------- write from requester 2 ----------------
        req = 4'b0100;
        we  = 4'b0100;
        addr_bus[2*AW +: AW] = 14'h0040;
        be_bus[2*2 +: 2]     = 2'b01;
        wd_bus[2*DW +: DW]   = 18'h155AA;
        cycle();
        chk("wr_gnt",   32'(seen_gnt),  32'b0100);
        chk("wr_wen",   32'(ram_wen),   32'd1);
        chk("wr_ren",   32'(ram_ren),   32'd0);
        chk("wr_addr",  32'(ram_addr),  32'h0040);
        chk("wr_be",    32'(ram_be),    32'b01);
        chk("wr_wdata", 32'(ram_wdata), 32'h155AA);
        idle_inputs();
        for (int i = 0; i < LAT + 1; i++) begin
            cycle();
            chk("wr_no_rvalid", 32'(seen_rv), 32'd0);
        end

        // ---------------- owner drops REQ mid-burst, requester 2 waits -----
        // Pointer is 3 here, so requester 0 wins the first arbitration.
        req  = 4'b0101;
        lock = 4'b0001;
        cycle();
        chk("drop_gnt0", 32'(seen_gnt), 32'b0001);
        cycle();
        chk("drop_gnt1", 32'(seen_gnt), 32'b0001);
        req  = 4'b0100;
        lock = 4'b0000;
        cycle();
        chk("drop_nogrant", 32'(seen_gnt), 32'b0000);
        cycle();
        chk("drop_gnt2", 32'(seen_gnt), 32'b0100);
        idle_inputs();
        drained = 0;
        for (int i = 0; i < LAT + 4 && drained == 0; i++) begin
            cycle();
            if (!busy) drained = 1;
        end
        chk("drop_busy_drains", 32'(drained), 32'd1);

        // ---------------- reset in the middle of reads ----------------
        req = 4'b0011;
        rand_payload();
        cycle();                       // read granted at N
        rand_payload();
        #2 rst_n = 1'b0;               // pulse low during N+1, before its edge
        #1;
        chk("mrst_rvalid", 32'(rvalid),  32'd0);
        chk("mrst_ren",    32'(ram_ren), 32'd0);
        chk("mrst_wen",    32'(ram_wen), 32'd0);
        chk("mrst_addr",   32'(ram_addr), 32'd0);
        chk("mrst_wdata",  32'(ram_wdata), 32'd0);
        chk("mrst_busy",   32'(busy),    32'd0);
        for (int i = 0; i < LAT + 1; i++) begin
            @(posedge clk); #1;
            chk("mrst_hold_rvalid", 32'(rvalid), 32'd0);
            chk("mrst_hold_ren",    32'(ram_ren), 32'd0);
        end
        rst_n = 1'b1;
        model_reset();
        req = 4'b1111;
        cycle();
        chk("mrst_ptr0_gnt", 32'(seen_gnt), 32'b0001);
        idle_inputs();
        for (int i = 0; i < LAT + 1; i++) cycle();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 2000; i++) begin
            req       = N'($urandom | $urandom);
            we        = N'($urandom);
            lock      = N'($urandom | $urandom);
            ram_rdata = DW'($urandom);
            rand_payload();
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < LAT + 2; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
